// File: rtl/l1l2_weight_accum_pkg.sv
// l1l2_pkg: constants, FSM state type and helpers shared by the L1->L2
// weight ROM, the weight accumulator and the L2 neuron-update stage.
//   NIN/NOUT   : L1 inputs per L2 neuron / L2 neuron count
//   BW/AW/ACCW : weight, ROM address and accumulator widths
//   state_e    : sequencer states
//   sext64     : sign-extend the low 'width' bits of a value to 64 bits
package l1l2_pkg;

    localparam int NIN  = 784;
    localparam int NOUT = 500;
    localparam int BW   = 14;
    localparam int AW   = 19;
    localparam int ACCW = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_e;

    // Shift the field's sign bit up to bit 63, then arithmetic-shift it
    // back down so the upper bits replicate it.
    function automatic logic [63:0] sext64(input logic [63:0] val,
                                           input int unsigned width);
        logic [63:0] shifted;
        shifted = val << (32'd64 - width);
        return 64'($signed(shifted) >>> (32'd64 - width));
    endfunction

endpackage

// File: rtl/l1l2_weight_accum.sv
// l1l2_weight_accum: sweeps the L1->L2 weight ROM linearly and forms one
// signed sum per L2 neuron. A weight is added wherever the captured L1 spike
// vector has a 1. Each sum is handed to the L2 stage over valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, spikes_in    begin a sweep (IDLE only) / spike vector captured then
//   busy                high whenever not IDLE
//   rom_addr, rom_en    ROM address and read enable
//   rom_data            ROM weight, combinational from rom_addr
//   sum_out, neuron_idx signed sum and its neuron index
//   out_valid/out_ready output handshake
//   done                one-cycle pulse after the last neuron is accepted
module l1l2_weight_accum
    import l1l2_pkg::*;
#(
    parameter int bW   = BW,
    parameter int nIn  = NIN,
    parameter int nOut = NOUT,
    parameter int aW   = AW,
    parameter int accW = ACCW,
    parameter int nW   = $clog2(nOut)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [nIn-1:0]   spikes_in,
    output logic             busy,
    output logic [aW-1:0]    rom_addr,
    output logic             rom_en,
    input  logic [bW-1:0]    rom_data,
    output logic [accW-1:0]  sum_out,
    output logic [nW-1:0]    neuron_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
);

    localparam int IW = (nIn > 1) ? $clog2(nIn) : 1;
    localparam logic [IW-1:0] I_ONE  = IW'(1);
    localparam logic [IW-1:0] I_LAST = IW'(nIn - 1);
    localparam logic [nW-1:0] J_ONE  = nW'(1);
    localparam logic [nW-1:0] J_LAST = nW'(nOut - 1);
    localparam logic [aW-1:0] A_ONE  = aW'(1);

    state_e                  state_q, state_d;
    logic [nIn-1:0]          spk_q, spk_d;
    logic [IW-1:0]           i_q, i_d;
    logic [nW-1:0]           j_q, j_d;
    logic [aW-1:0]           addr_q, addr_d;
    logic signed [accW-1:0]  acc_q, acc_d;
    logic signed [accW-1:0]  sum_q, sum_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    busy_q, rom_en_q;
    logic signed [accW-1:0]  term_s;
    logic signed [accW-1:0]  acc_sum_s;

    // Contribution of the current ROM word: the weight where the spike is set.
    always_comb begin
        if (spk_q[i_q]) begin
            term_s = accW'(sext64(64'(rom_data), bW));
        end else begin
            term_s = {accW{1'b0}};
        end
        acc_sum_s = acc_q + term_s;
    end

    // Next-state logic of the IDLE -> ACCUM -> EMIT sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (i_q == I_LAST) begin
                    state_d = EMIT;
                end else begin
                    state_d = ACCUM;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (j_q == J_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: counters, address, accumulator and output regs.
    always_comb begin
        spk_d   = spk_q;
        i_d     = i_q;
        j_d     = j_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    spk_d  = spikes_in;
                    i_d    = {IW{1'b0}};
                    j_d    = {nW{1'b0}};
                    addr_d = {aW{1'b0}};
                    acc_d  = {accW{1'b0}};
                end else begin
                    spk_d = spk_q;
                end
            end
            ACCUM: begin
                // The address simply counts, so it equals j*nIn + i without
                // any multiply; it ends each neuron one past its last word.
                addr_d = addr_q + A_ONE;
                if (i_q == I_LAST) begin
                    sum_d   = acc_sum_s;
                    valid_d = 1'b1;
                    acc_d   = {accW{1'b0}};
                    i_d     = {IW{1'b0}};
                end else begin
                    acc_d = acc_sum_s;
                    i_d   = i_q + I_ONE;
                end
            end
            EMIT: begin
                // valid is always high in EMIT, so ready alone completes it.
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (j_q == J_LAST) begin
                        done_d = 1'b1;
                        addr_d = {aW{1'b0}};
                    end else begin
                        j_d = j_q + J_ONE;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; rom_en/busy are registered decodes of
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            spk_q    <= {nIn{1'b0}};
            i_q      <= {IW{1'b0}};
            j_q      <= {nW{1'b0}};
            addr_q   <= {aW{1'b0}};
            acc_q    <= {accW{1'b0}};
            sum_q    <= {accW{1'b0}};
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rom_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            spk_q    <= spk_d;
            i_q      <= i_d;
            j_q      <= j_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
            rom_en_q <= (state_d == ACCUM);
        end
    end

    assign busy       = busy_q;
    assign rom_addr   = addr_q;
    assign rom_en     = rom_en_q;
    assign sum_out    = sum_q;
    assign neuron_idx = j_q;
    assign out_valid  = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_l1l2_weight_accum.sv
// Directed bench for l1l2_weight_accum on a small build (nIn=4, nOut=3,
// aW=4). A behavioural ROM supplies either w[a]=a-6, all -8192 or all +8191.
module tb_l1l2_weight_accum;

    localparam int NI  = 4;
    localparam int NO  = 3;
    localparam int AWT = 4;
    localparam int BWT = 14;
    localparam int ACW = 24;
    localparam int NWT = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [NI-1:0]    spikes_in;
    logic             busy;
    logic [AWT-1:0]   rom_addr;
    logic             rom_en;
    logic [BWT-1:0]   rom_data;
    logic [ACW-1:0]   sum_out;
    logic [NWT-1:0]   neuron_idx;
    logic             out_valid;
    logic             out_ready;
    logic             done;

    int checks       = 0;
    int failures     = 0;
    int rom_mode     = 0;
    int sweep_cycles = 0;

    l1l2_weight_accum #(
        .bW   (BWT),
        .nIn  (NI),
        .nOut (NO),
        .aW   (AWT),
        .accW (ACW),
        .nW   (NWT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .spikes_in  (spikes_in),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .sum_out    (sum_out),
        .neuron_idx (neuron_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural weight ROM, combinational from the address.
    always_comb begin
        case (rom_mode)
            0:       rom_data = 14'(int'(rom_addr) - 6);
            1:       rom_data = 14'h2000;
            2:       rom_data = 14'h1FFF;
            default: rom_data = 14'h0000;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input logic [NI-1:0] spk);
        start     = 1'b1;
        spikes_in = spk;
        tick();
        start        = 1'b0;
        spikes_in    = ~spk;
        sweep_cycles = 0;
        chk("start_busy", longint'(busy), 64'sd1);
        chk("start_rom_en", longint'(rom_en), 64'sd1);
    endtask

    // Called on the first ACCUM cycle of neuron j; returns on the cycle after
    // its handshake. hold = extra EMIT cycles with out_ready low; pulse
    // raises start (with a different spike vector) mid-accumulation.
    task automatic run_neuron(input int j, input longint exp_sum,
                              input int hold, input bit pulse);
        out_ready = (hold > 0) ? 1'b0 : 1'b1;
        for (int k = 0; k < NI; k++) begin
            chk("accum_rom_en", longint'(rom_en), 64'sd1);
            chk("accum_addr", longint'(rom_addr), longint'(j * NI + k));
            chk("accum_idx", longint'(neuron_idx), longint'(j));
            if (pulse && k == 1) begin
                start     = 1'b1;
                spikes_in = 4'b1111;
            end else begin
                start = 1'b0;
            end
            tick();
            sweep_cycles++;
        end
        start = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                tick();
                sweep_cycles++;
            end
            chk("emit_valid", longint'(out_valid), 64'sd1);
            chk("emit_sum", longint'($signed(sum_out)), exp_sum);
            chk("emit_idx", longint'(neuron_idx), longint'(j));
            chk("emit_rom_en", longint'(rom_en), 64'sd0);
            chk("emit_addr", longint'(rom_addr), longint'((j + 1) * NI));
            chk("emit_busy", longint'(busy), 64'sd1);
        end
        out_ready = 1'b1;
        tick();
        sweep_cycles++;
    endtask

    task automatic check_done();
        chk("done_pulse", longint'(done), 64'sd1);
        chk("done_busy", longint'(busy), 64'sd0);
        chk("done_addr", longint'(rom_addr), 64'sd0);
        chk("done_valid", longint'(out_valid), 64'sd0);
        tick();
        chk("done_clear", longint'(done), 64'sd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        spikes_in = 4'b0000;
        rom_mode  = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", longint'(busy), 64'sd0);
        chk("rst_rom_en", longint'(rom_en), 64'sd0);
        chk("rst_addr", longint'(rom_addr), 64'sd0);
        chk("rst_valid", longint'(out_valid), 64'sd0);
        chk("rst_done", longint'(done), 64'sd0);
        chk("rst_sum", longint'($signed(sum_out)), 64'sd0);
        chk("rst_idx", longint'(neuron_idx), 64'sd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", longint'(busy), 64'sd0);

        // Ramp weights a-6, spikes bits 0,1,3: sums -14, -2, 10
        rom_mode = 0;
        start_sweep(4'b1011);
        run_neuron(0, -64'sd14, 0, 1'b0);
        run_neuron(1, -64'sd2, 0, 1'b0);
        run_neuron(2, 64'sd10, 0, 1'b0);
        chk("sweep_cycles", longint'(sweep_cycles), longint'(NO * (NI + 1)));
        check_done();

        // All weights -8192, all spikes: -32768 each; neuron 1 stalled 10 cycles
        rom_mode = 1;
        start_sweep(4'b1111);
        run_neuron(0, -64'sd32768, 0, 1'b0);
        run_neuron(1, -64'sd32768, 10, 1'b0);
        run_neuron(2, -64'sd32768, 0, 1'b0);
        check_done();

        // All weights +8191, no spikes: every sum 0
        rom_mode = 2;
        start_sweep(4'b0000);
        run_neuron(0, 64'sd0, 0, 1'b0);
        run_neuron(1, 64'sd0, 0, 1'b0);
        run_neuron(2, 64'sd0, 0, 1'b0);
        check_done();

        // Reset at i=2 of neuron 2
        rom_mode = 0;
        start_sweep(4'b1011);
        run_neuron(0, -64'sd14, 0, 1'b0);
        run_neuron(1, -64'sd2, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("pre_rst_addr", longint'(rom_addr), longint'(2 * NI + k));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", longint'(busy), 64'sd0);
        chk("mid_rst_rom_en", longint'(rom_en), 64'sd0);
        chk("mid_rst_addr", longint'(rom_addr), 64'sd0);
        chk("mid_rst_valid", longint'(out_valid), 64'sd0);
        chk("mid_rst_done", longint'(done), 64'sd0);
        chk("mid_rst_sum", longint'($signed(sum_out)), 64'sd0);
        chk("mid_rst_idx", longint'(neuron_idx), 64'sd0);

        // Fresh start with spikes bits 1,2: sums -9, -1, 7; start pulsed mid-sweep
        start_sweep(4'b0110);
        run_neuron(0, -64'sd9, 0, 1'b1);
        run_neuron(1, -64'sd1, 0, 1'b0);
        run_neuron(2, 64'sd7, 0, 1'b0);
        check_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1l2_weight_accum.md
# l1l2_weight_accum

Sequencer and accumulator that sits directly downstream of the L1→L2 weight ROM. It sweeps the ROM address space linearly, drives the ROM read enable, and forms a signed weighted sum per L2 neuron. Each sum adds the weight wherever the captured L1 spike vector has a 1. Per-neuron sums are emitted over a valid/ready handshake to the L2 neuron-update stage.

## Interface
Parameters:
- bW, 14: weight bitwidth; weights are signed two's complement.
- nIn, 784: L1 inputs per L2 neuron.
- nOut, 500: L2 neuron count.
- aW, 19: ROM address width; must satisfy 2^aW ≥ nIn·nOut.
- accW, 24: accumulator/sum width; must satisfy accW ≥ bW + clog2(nIn).
- nW, clog2(nOut) = 9: neuron index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a full sweep; honoured only in IDLE.
- spikes_in  in  nIn  L1 spike vector, sampled on the accepted start.
- busy  out  1  high whenever the state is not IDLE.
- rom_addr  out  aW  ROM address.
- rom_en  out  1  ROM read enable.
- rom_data  in  bW  ROM data; combinational from rom_addr in the same cycle.
- sum_out  out  accW  signed weighted sum for neuron neuron_idx.
- neuron_idx  out  nW  index of the neuron being accumulated or emitted.
- out_valid  out  1  sum_out/neuron_idx valid.
- out_ready  in  1  consumer accepts.
- done  out  1  one-cycle pulse after the last neuron is accepted.

## Operation
States: IDLE, ACCUM, EMIT.

IDLE:
- rom_en=0, out_valid=0.
- On start: register spikes_in into spk_q; set i=0, j=0, acc=0, rom_addr=0; go to ACCUM.

ACCUM:
- rom_en=1.
- Each cycle: acc ← acc + (spk_q[i] ? sign_extend(rom_data) : 0).
- i increments; rom_addr increments by 1 every cycle.
- The address is linear across neurons, so rom_addr = j·nIn + i always holds. No multiplier is used.
- On the cycle with i = nIn−1:
  - sum_out ← final acc, including this cycle's term.
  - out_valid ← 1, acc ← 0, i ← 0.
  - Go to EMIT.

EMIT:
- rom_en=0; rom_addr holds the next address.
- sum_out and neuron_idx are held stable while out_valid=1 and out_ready=0.
- On out_valid && out_ready:
  - out_valid ← 0.
  - If j = nOut−1: pulse done, go to IDLE, rom_addr ← 0.
  - Else: j ← j+1, go to ACCUM.

Other rules:
- start while busy is ignored. spikes_in changes after capture have no effect.
- Arithmetic: signed; overflow is impossible given the accW constraint; no saturation.
- Reset (any state, including mid-sweep):
  - state=IDLE.
  - rom_addr, rom_en, sum_out, neuron_idx, out_valid, done, busy, acc, i, j all become 0.
  - The partial sweep is discarded.

## Timing
- Start accept to first rom_en=1: 1 cycle (ACCUM is entered on the edge after start).
- Per neuron: exactly nIn ACCUM cycles, then ≥1 EMIT cycle.
- out_valid rises on the edge ending the last ACCUM cycle.
- Full sweep with out_ready tied high: nOut·(nIn+1) cycles from the first ACCUM cycle to the done pulse. Defaults: 392 500 cycles.
- Last address driven: nIn·nOut−1, which is 391 999 by default.
- done is asserted in the cycle after the final handshake, coincident with busy=0.
- A start accepted in the same cycle as done is not possible, because done occurs in IDLE. A start in the first IDLE cycle after done is accepted.
- Backpressure: out_ready low stalls in EMIT indefinitely; rom_en stays 0 during the stall.

## Structure
- Shared package l1l2_pkg:
  - default constants NIN=784, NOUT=500, BW=14, AW=19, ACCW=24.
  - state enum {IDLE, ACCUM, EMIT}.
  - sign-extension function.
- The ROM and L2 stage import the same constants.
- Single module; no sub-module needed. The counter/accumulator datapath and the FSM live in one file.

## Test plan
- Small build (nIn=4, nOut=3, aW=4). ROM model holds weights w[a]=a−6; start with spikes=4'b1011 (bits 0, 1, 3 set). Required per neuron j, with inputs i=0,1,3 at a=4j+i:
  - j=0: a=0,1,3 → −6 −5 −3 = −14.
  - j=1: a=4,5,7 → −2 −1 +1 = −2.
  - j=2: a=8,9,11 → +2 +3 +5 = 10.
  - Result: sum_out = −14, −2, 10; neuron_idx = 0, 1, 2; done after the third accept.
- Address sweep, default parameters, out_ready=1:
  - rom_addr runs 0..391 999 contiguously while rom_en=1.
  - rom_en=0 for exactly one cycle between neurons.
  - done arrives 392 500 cycles after the first ACCUM cycle.
- Extremes:
  - All weights −8192, all spikes 1 → every sum = −6 422 528.
  - All weights +8191, all spikes 0 → every sum = 0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles on neuron 1 → sum_out/neuron_idx stable, rom_en=0, rom_addr=1568 held.
  - Release → ACCUM resumes at 1568.
- Reset and start filtering:
  - Assert rst at i=300 of neuron 2 → next cycle all outputs 0, IDLE.
  - Fresh start → sweep restarts from address 0 with the newly captured spikes.
  - start pulsed mid-sweep → no effect on counters or spk_q.
